// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction cache (A) and data cache (B) share one memory port;
// writeback runs before fill under one grant. Define MARB_ROUND_ROBIN_EN for round-robin tie-break.
module mem_arbiter #(
    parameter int ADD_WIDTH  = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_ren,
    input  logic                  a_wen,
    input  logic [ADD_WIDTH-1:0]  a_rd_addr,
    input  logic [ADD_WIDTH-1:0]  a_wr_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_done,
    input  logic                  b_ren,
    input  logic                  b_wen,
    input  logic [ADD_WIDTH-1:0]  b_rd_addr,
    input  logic [ADD_WIDTH-1:0]  b_wr_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_done,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADD_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic                    owner_r;      // 1'b0 = A, 1'b1 = B
    logic                    ren_r;
    logic [ADD_WIDTH-1:0]    rd_addr_r;
    logic [ADD_WIDTH-1:0]    mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic [DATA_WIDTH-1:0]   a_rdata_r;
    logic [DATA_WIDTH-1:0]   b_rdata_r;
    logic                    mem_ren_r;
    logic                    mem_wen_r;
    logic                    a_done_r;
    logic                    b_done_r;
    logic                    busy_r;

    logic                    a_req_s;
    logic                    b_req_s;
    logic                    grant_b_s;
    logic                    start_s;
    logic                    sel_ren_s;
    logic                    sel_wen_s;
    logic [ADD_WIDTH-1:0]    sel_rd_addr_s;
    logic [ADD_WIDTH-1:0]    sel_wr_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;

`ifdef MARB_ROUND_ROBIN_EN
    logic                    last_grant_r; // 1'b0 = A, 1'b1 = B

    // Remember the most recent grant so a tie goes to the other port.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= 1'b0;
        end else if (start_s) begin
            last_grant_r <= grant_b_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Request detection, arbitration and selection of the granted port's request.
    always_comb begin
        a_req_s = a_ren | a_wen;
        b_req_s = b_ren | b_wen;
`ifdef MARB_ROUND_ROBIN_EN
        grant_b_s = b_req_s & (~a_req_s | ~last_grant_r);
`else
        grant_b_s = b_req_s & ~a_req_s;
`endif
        start_s = (state_r == IDLE) & (a_req_s | b_req_s);
        if (grant_b_s) begin
            sel_ren_s     = b_ren;
            sel_wen_s     = b_wen;
            sel_rd_addr_s = b_rd_addr;
            sel_wr_addr_s = b_wr_addr;
            sel_wdata_s   = b_wdata;
        end else begin
            sel_ren_s     = a_ren;
            sel_wen_s     = a_wen;
            sel_rd_addr_s = a_rd_addr;
            sel_wr_addr_s = a_wr_addr;
            sel_wdata_s   = a_wdata;
        end
    end

    // Next-state logic; acks are only honoured in WRITE and READ.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nx_s = sel_wen_s ? WRITE : READ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_nx_s = ren_r ? READ : DONE;
                end else begin
                    state_nx_s = WRITE;
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = READ;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant capture, memory address/data, read-data return and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r     <= 1'b0;
            ren_r       <= 1'b0;
            rd_addr_r   <= {ADD_WIDTH{1'b0}};
            mem_addr_r  <= {ADD_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            a_rdata_r   <= {DATA_WIDTH{1'b0}};
            b_rdata_r   <= {DATA_WIDTH{1'b0}};
            mem_ren_r   <= 1'b0;
            mem_wen_r   <= 1'b0;
            a_done_r    <= 1'b0;
            b_done_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (start_s) begin
                owner_r     <= grant_b_s;
                ren_r       <= sel_ren_s;
                rd_addr_r   <= sel_rd_addr_s;
                mem_addr_r  <= sel_wen_s ? sel_wr_addr_s : sel_rd_addr_s;
                mem_wdata_r <= sel_wdata_s;
            end else if ((state_r == WRITE) && mem_ack && ren_r) begin
                mem_addr_r  <= rd_addr_r;
            end else begin
                mem_addr_r  <= mem_addr_r;
            end
            if ((state_r == READ) && mem_ack && !owner_r) begin
                a_rdata_r <= mem_rdata;
            end else if ((state_r == READ) && mem_ack && owner_r) begin
                b_rdata_r <= mem_rdata;
            end else begin
                a_rdata_r <= a_rdata_r;
            end
            // Strobes and done are decoded from the next state so they line up with it.
            mem_wen_r <= (state_nx_s == WRITE);
            mem_ren_r <= (state_nx_s == READ);
            busy_r    <= (state_nx_s != IDLE);
            a_done_r  <= (state_nx_s == DONE) & ~owner_r;
            b_done_r  <= (state_nx_s == DONE) & owner_r;
        end
    end

    assign a_rdata   = a_rdata_r;
    assign b_rdata   = b_rdata_r;
    assign a_done    = a_done_r;
    assign b_done    = b_done_r;
    assign mem_ren   = mem_ren_r;
    assign mem_wen   = mem_wen_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow MARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ren, a_wen, b_ren, b_wen;
    logic [11:0] a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_done, b_done;
    logic        mem_ren, mem_wen, mem_ack, busy;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADD_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .a_ren(a_ren), .a_wen(a_wen), .a_rd_addr(a_rd_addr), .a_wr_addr(a_wr_addr),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_done(a_done),
        .b_ren(b_ren), .b_wen(b_wen), .b_rd_addr(b_rd_addr), .b_wr_addr(b_wr_addr),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_done(b_done),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One zero-wait read grant: request already held, ends in the IDLE cycle after done.
    task automatic serve_read(input logic is_b, input logic [11:0] addr, input logic [31:0] data);
        tick();
        chk("rd_ren", 32'(mem_ren), 32'd1);
        chk("rd_wen", 32'(mem_wen), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'(addr));
        chk("rd_busy", 32'(busy), 32'd1);
        tick();
        chk("rd_nodone_a", 32'(a_done), 32'd0);
        chk("rd_nodone_b", 32'(b_done), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack = 1'b0;
        chk("rd_done_a", 32'(a_done), 32'(!is_b));
        chk("rd_done_b", 32'(b_done), 32'(is_b));
        chk("rd_data", is_b ? b_rdata : a_rdata, data);
        chk("rd_strobe_off", 32'(mem_ren), 32'd0);
        tick();
        chk("rd_idle_busy", 32'(busy), 32'd0);
        chk("rd_idle_done", 32'({a_done, b_done}), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        {a_ren, a_wen, b_ren, b_wen, mem_ack} = 5'b0;
        a_rd_addr = 12'h000; a_wr_addr = 12'h000; b_rd_addr = 12'h000; b_wr_addr = 12'h000;
        a_wdata = 32'h0; b_wdata = 32'h0; mem_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({mem_ren, mem_wen}), 32'd0);
        chk("rst_done", 32'({a_done, b_done}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);

        // A read-only: done in the fourth cycle counting the request cycle.
        a_rd_addr = 12'h134;
        a_ren = 1'b1;
        serve_read(1'b0, 12'h134, 32'hDEADBEEF);
        a_ren = 1'b0;
        chk("a_rd_b_rdata", b_rdata, 32'd0);

        // B writeback then fill; inputs scrambled after grant must not matter.
        b_wr_addr = 12'h2A0; b_wdata = 32'h12345678; b_rd_addr = 12'h5A0;
        b_wen = 1'b1; b_ren = 1'b1;
        tick();
        chk("wb_wen", 32'(mem_wen), 32'd1);
        chk("wb_ren", 32'(mem_ren), 32'd0);
        chk("wb_addr", 32'(mem_addr), 32'h2A0);
        chk("wb_wdata", mem_wdata, 32'h12345678);
        b_wr_addr = 12'hFFF; b_rd_addr = 12'h001; b_wdata = 32'h0;
        tick();
        chk("wb_hold_addr", 32'(mem_addr), 32'h2A0);
        chk("wb_hold_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wb_fill_ren", 32'(mem_ren), 32'd1);
        chk("wb_fill_wen", 32'(mem_wen), 32'd0);
        chk("wb_fill_addr", 32'(mem_addr), 32'h5A0);
        chk("wb_fill_nodone", 32'(b_done), 32'd0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        chk("wb_b_done", 32'(b_done), 32'd1);
        chk("wb_a_done", 32'(a_done), 32'd0);
        chk("wb_b_rdata", b_rdata, 32'hCAFEF00D);
        chk("wb_a_rdata_kept", a_rdata, 32'hDEADBEEF);
        tick();
        b_wen = 1'b0; b_ren = 1'b0;
        chk("wb_idle_done", 32'(b_done), 32'd0);
        chk("wb_idle_busy", 32'(busy), 32'd0);

        // Stray ack in IDLE is ignored; then an A write-only leaves a_rdata alone.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_strobes", 32'({mem_ren, mem_wen}), 32'd0);
        a_wr_addr = 12'h010; a_wdata = 32'h55AA55AA; a_wen = 1'b1;
        tick();
        chk("wo_wen", 32'(mem_wen), 32'd1);
        chk("wo_addr", 32'(mem_addr), 32'h010);
        chk("wo_wdata", mem_wdata, 32'h55AA55AA);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wo_done", 32'(a_done), 32'd1);
        chk("wo_no_read", 32'(mem_ren), 32'd0);
        chk("wo_rdata_kept", a_rdata, 32'hDEADBEEF);
        tick();
        a_wen = 1'b0;
        chk("wo_done_once", 32'(a_done), 32'd0);

        // Five wait states in READ.
        a_rd_addr = 12'h3FC; a_ren = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("ws_ren", 32'(mem_ren), 32'd1);
            chk("ws_addr", 32'(mem_addr), 32'h3FC);
            chk("ws_nodone", 32'(a_done), 32'd0);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 1'b0;
        chk("ws_done", 32'(a_done), 32'd1);
        chk("ws_rdata", a_rdata, 32'h0BADF00D);
        tick();
        a_ren = 1'b0;
        chk("ws_done_end", 32'(a_done), 32'd0);
        tick();
        chk("ws_idle", 32'({busy, a_done}), 32'd0);

        // Reset in the second WRITE cycle aborts silently.
        b_wr_addr = 12'h7F0; b_wdata = 32'hA5A5A5A5; b_wen = 1'b1;
        tick();
        chk("ab_wen1", 32'(mem_wen), 32'd1);
        tick();
        chk("ab_wen2", 32'(mem_wen), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; b_wen = 1'b0;
        chk("ab_wen_off", 32'(mem_wen), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_nodone", 32'({a_done, b_done}), 32'd0);
        chk("ab_addr", 32'(mem_addr), 32'd0);
        chk("ab_wdata", mem_wdata, 32'd0);
        chk("ab_a_rdata", a_rdata, 32'd0);
        chk("ab_b_rdata", b_rdata, 32'd0);
        tick();
        chk("ab_still_idle", 32'({busy, b_done}), 32'd0);
        b_rd_addr = 12'h444; b_ren = 1'b1;
        serve_read(1'b1, 12'h444, 32'h13572468);
        b_ren = 1'b0;

        // Simultaneous held reads from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        a_rd_addr = 12'h100; b_rd_addr = 12'h200;
        a_ren = 1'b1; b_ren = 1'b1;
`ifdef MARB_ROUND_ROBIN_EN
        serve_read(1'b1, 12'h200, 32'h11111111);
        serve_read(1'b0, 12'h100, 32'h22222222);
        serve_read(1'b1, 12'h200, 32'h33333333);
`else
        serve_read(1'b0, 12'h100, 32'h11111111);
        serve_read(1'b0, 12'h100, 32'h22222222);
        serve_read(1'b0, 12'h100, 32'h33333333);
        a_ren = 1'b0;
        serve_read(1'b1, 12'h200, 32'h44444444);
`endif
        a_ren = 1'b0; b_ren = 1'b0;
        tick();
        chk("arb_end_idle", 32'({busy, mem_ren, mem_wen}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
